// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: handshake FSM states and register offsets.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    WAIT_DROP = 2'd2
  } irq_state_e;

  // Byte offsets inside the 32-byte register window.
  localparam logic [4:0] REG_PENDING  = 5'h00;
  localparam logic [4:0] REG_ENABLE   = 5'h08;
  localparam logic [4:0] REG_OVERFLOW = 5'h10;
  localparam logic [4:0] REG_CURRENT  = 5'h18;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser with rising-edge or level detection; hit_o is valid for one cycle
// per detected event (or every cycle while a level source is high).
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          LEVEL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic hit_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      prev_q <= synced;
    end
  end

  assign hit_o = LEVEL ? synced : (synced & ~prev_q);

endmodule

// File: rtl/irq_controller.sv
// Multi-source interrupt controller: pending/enable/overflow registers, lowest-index priority,
// vector/ack handshake FSM and a 64-bit memory-mapped register window.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned         N_IRQ       = 8,
  parameter int unsigned         VEC_W       = 4,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0]    LEVEL_MASK  = '0,
  parameter logic [63:0]         BASE_ADDR   = 64'h0000_ff00,
  parameter logic [N_IRQ-1:0]    EN_RESET    = '1
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic [N_IRQ-1:0] irq_src,
  output logic [VEC_W-1:0] interrupt_vector,
  input  logic             interrupt_ack,
  input  logic [63:0]      bus_address,
  input  logic [63:0]      bus_write_data,
  input  logic             bus_write_enable,
  input  logic             bus_read_enable,
  output logic [63:0]      bus_read_data,
  output logic             bus_hit
);

  logic [N_IRQ-1:0] hit;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] enable_q, enable_d;
  logic [N_IRQ-1:0] overflow_q, overflow_d;
  logic [N_IRQ-1:0] req, cur_oh, ack_clr, pend_w1c, ovf_w1c;
  logic [VEC_W-1:0] vec_q, vec_d, win;
  logic [63:0]      rdata_q, rdata_d, rd_val;
  logic [4:0]       reg_off;
  logic             wr_hit, cur_en;
  irq_state_e       state_q, state_d;

  for (genvar g = 0; g < N_IRQ; g++) begin : gen_src
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .LEVEL       (LEVEL_MASK[g])
    ) u_sync (
      .clk_i  (CLOCK_50),
      .rst_ni (KEY0),
      .src_i  (irq_src[g]),
      .hit_o  (hit[g])
    );
  end

  assign bus_hit  = (bus_address[63:5] == BASE_ADDR[63:5]);
  assign reg_off  = {bus_address[4:3], 3'b000};
  assign wr_hit   = bus_write_enable & bus_hit;

  // Sub-word address bits and data bits above the source count carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus_address[2:0], bus_write_data[63:N_IRQ]};

  assign req    = pending_q & enable_q;
  assign cur_oh = {{(N_IRQ-1){1'b0}}, 1'b1} << (vec_q - VEC_W'(1));
  assign cur_en = |(enable_q & cur_oh);

  // Scan downward so the lowest requesting index is the last (winning) assignment.
  always_comb begin
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) win = VEC_W'(i + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ack_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          vec_d   = win;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (interrupt_ack) begin
          ack_clr = cur_oh;
          vec_d   = '0;
          state_d = WAIT_DROP;
        end else if (!cur_en) begin
          vec_d   = '0;
          state_d = IDLE;
        end
      end
      WAIT_DROP: begin
        if (!interrupt_ack) state_d = IDLE;
      end
      default: begin
        vec_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pend_w1c = (wr_hit && reg_off == REG_PENDING)  ? bus_write_data[N_IRQ-1:0] : '0;
  assign ovf_w1c  = (wr_hit && reg_off == REG_OVERFLOW) ? bus_write_data[N_IRQ-1:0] : '0;

  // New events are OR-ed in after clearing so a simultaneous set always wins.
  assign pending_d  = (pending_q & ~(pend_w1c | ack_clr)) | hit;
  assign overflow_d = (overflow_q & ~ovf_w1c) | (hit & ~LEVEL_MASK & pending_q);
  assign enable_d   = (wr_hit && reg_off == REG_ENABLE) ? bus_write_data[N_IRQ-1:0] : enable_q;

  always_comb begin
    rd_val = '0;
    case (reg_off)
      REG_PENDING:  rd_val[N_IRQ-1:0] = pending_q;
      REG_ENABLE:   rd_val[N_IRQ-1:0] = enable_q;
      REG_OVERFLOW: rd_val[N_IRQ-1:0] = overflow_q;
      REG_CURRENT:  rd_val[VEC_W+1:0] = {state_q, vec_q};
      default:      rd_val = '0;
    endcase
  end

  assign rdata_d = (bus_read_enable && bus_hit) ? rd_val : rdata_q;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      pending_q  <= '0;
      enable_q   <= EN_RESET;
      overflow_q <= '0;
      vec_q      <= '0;
      state_q    <= IDLE;
      rdata_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      vec_q      <= vec_d;
      state_q    <= state_d;
      rdata_q    <= rdata_d;
    end
  end

  assign interrupt_vector = vec_q;
  assign bus_read_data    = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: reset/decode table, directed handshake sequences and randomized
// traffic compared every cycle against a rule-level reference model.
module tb_irq_controller;

  localparam int unsigned N    = 8;
  localparam int unsigned S    = 2;
  localparam logic [7:0]  LVL  = 8'h80;
  localparam logic [63:0] BASE = 64'h0000_ff00;

  logic        CLOCK_50;
  logic        KEY0;
  logic [7:0]  irq_src;
  logic [3:0]  interrupt_vector;
  logic        interrupt_ack;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic        bus_hit;

  irq_controller #(
    .N_IRQ       (N),
    .VEC_W       (4),
    .SYNC_STAGES (S),
    .LEVEL_MASK  (LVL),
    .BASE_ADDR   (BASE),
    .EN_RESET    (8'hFF)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .KEY0             (KEY0),
    .irq_src          (irq_src),
    .interrupt_vector (interrupt_vector),
    .interrupt_ack    (interrupt_ack),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .bus_hit          (bus_hit)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw-input history stands in for the synchroniser delay.
  logic [7:0]  m_h [0:S];
  logic [7:0]  m_pend, m_en, m_ovf;
  int          m_state;  // 0 idle, 1 presenting, 2 waiting for ack release
  int          m_vec;
  logic [63:0] m_rdata;

  task automatic model_reset();
    for (int j = 0; j <= S; j++) m_h[j] = 8'h00;
    m_pend = 8'h00; m_en = 8'hFF; m_ovf = 8'h00;
    m_state = 0; m_vec = 0; m_rdata = 64'h0;
  endtask

  function automatic logic [63:0] m_reg(input int off);
    case (off)
      0:       return 64'(m_pend);
      1:       return 64'(m_en);
      2:       return 64'(m_ovf);
      default: return 64'((m_state << 4) | m_vec);
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] synced, prev, events, clr_p, clr_o, req;
    bit         in_win;
    int         off, win;
    synced = m_h[S-1];
    prev   = m_h[S];
    events = (synced & LVL) | (synced & ~prev & ~LVL);
    in_win = (bus_address >> 5) == (BASE >> 5);
    off    = int'(bus_address[4:3]);
    clr_p  = 8'h00;
    clr_o  = 8'h00;
    if (bus_read_enable && in_win) m_rdata = m_reg(off);
    req = m_pend & m_en;
    case (m_state)
      0: begin
        win = -1;
        for (int i = 0; i < int'(N); i++) begin
          if (req[i]) begin
            win = i;
            break;
          end
        end
        if (win >= 0) begin
          m_vec = win + 1;
          m_state = 1;
        end
      end
      1: begin
        if (interrupt_ack) begin
          clr_p[m_vec-1] = 1'b1;
          m_vec = 0;
          m_state = 2;
        end else if (!m_en[m_vec-1]) begin
          m_vec = 0;
          m_state = 0;
        end
      end
      default: if (!interrupt_ack) m_state = 0;
    endcase
    if (bus_write_enable && in_win) begin
      case (off)
        0:       clr_p = clr_p | bus_write_data[7:0];
        1:       m_en = bus_write_data[7:0];
        2:       clr_o = bus_write_data[7:0];
        default: ;
      endcase
    end
    m_ovf  = (m_ovf & ~clr_o) | (events & ~LVL & m_pend);
    m_pend = (m_pend & ~clr_p) | events;
    for (int j = S; j > 0; j--) m_h[j] = m_h[j-1];
    m_h[0] = irq_src;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLOCK_50);
    #1;
    check("vector", 64'(interrupt_vector), 64'(m_vec));
    check("read_data", bus_read_data, m_rdata);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_wr(input logic [63:0] addr, input logic [63:0] data);
    bus_address = addr; bus_write_data = data; bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [63:0] addr, output logic [63:0] data);
    bus_address = addr; bus_read_enable = 1'b1;
    tick();
    bus_read_enable = 1'b0;
    data = bus_read_data;
  endtask

  task automatic pulse(input int i);
    irq_src[i] = 1'b1;
    ticks(2);
    irq_src[i] = 1'b0;
    tick();
  endtask

  task automatic wait_vec(input string name, input int exp, input int budget);
    int n = 0;
    while (int'(interrupt_vector) != exp && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(interrupt_vector), 64'(exp));
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        exp_hit;
    logic [63:0] exp_rdata;
  } rd_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rd_vec_t     tbl [9];
    logic [63:0] d;

    tbl[0] = '{64'h0000_ff00, 1'b1, 64'h00};
    tbl[1] = '{64'h0000_ff08, 1'b1, 64'hFF};
    tbl[2] = '{64'h0000_ff10, 1'b1, 64'h00};
    tbl[3] = '{64'h0000_ff18, 1'b1, 64'h00};
    tbl[4] = '{64'h0000_ff20, 1'b0, 64'h00};
    tbl[5] = '{64'h0000_fef8, 1'b0, 64'h00};
    tbl[6] = '{64'h0000_ff08, 1'b1, 64'hFF};
    tbl[7] = '{64'h0001_ff08, 1'b0, 64'hFF};
    tbl[8] = '{64'h0000_ff28, 1'b0, 64'hFF};

    KEY0 = 1'b0; irq_src = 8'h00; interrupt_ack = 1'b0;
    bus_address = 64'h0; bus_write_data = 64'h0;
    bus_write_enable = 1'b0; bus_read_enable = 1'b0;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("reset_vector", 64'(interrupt_vector), 64'h0);
    check("reset_rdata", bus_read_data, 64'h0);
    @(negedge CLOCK_50);
    KEY0 = 1'b1;

    // Reset values and address decode.
    for (int k = 0; k < 9; k++) begin
      bus_address = tbl[k].addr;
      bus_read_enable = 1'b1;
      #1;
      check($sformatf("bus_hit[%0d]", k), 64'(bus_hit), 64'(tbl[k].exp_hit));
      tick();
      bus_read_enable = 1'b0;
      check($sformatf("table_rdata[%0d]", k), bus_read_data, tbl[k].exp_rdata);
    end
    bus_address = BASE + 64'h40;

    // Single edge source through the handshake.
    irq_src[3] = 1'b1;
    ticks(4);
    irq_src[3] = 1'b0;
    check("t2_vector4", 64'(interrupt_vector), 64'h4);
    interrupt_ack = 1'b1;
    tick();
    check("t2_ack_clears_vec", 64'(interrupt_vector), 64'h0);
    bus_rd(BASE + 64'h00, d);
    check("t2_pending_clear", d, 64'h0);
    tick();
    check("t2_vec_held_zero", 64'(interrupt_vector), 64'h0);
    interrupt_ack = 1'b0;
    ticks(3);

    // Priority with no preemption.
    irq_src[5] = 1'b1;
    ticks(2);
    irq_src[5] = 1'b0;
    wait_vec("t3_vec6", 6, 6);
    pulse(1);
    ticks(3);
    check("t3_no_preempt", 64'(interrupt_vector), 64'h6);
    bus_rd(BASE + 64'h18, d);
    check("t3_current", d, 64'h16);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    wait_vec("t3_vec2", 2, 4);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    ticks(2);
    check("t3_idle", 64'(interrupt_vector), 64'h0);

    // Overflow and its W1C, with data bits above the source count ignored.
    pulse(2);
    pulse(2);
    ticks(3);
    bus_rd(BASE + 64'h10, d);
    check("t4_overflow", d, 64'h04);
    bus_wr(BASE + 64'h10, 64'hFFFF_0000_0000_0004);
    bus_rd(BASE + 64'h10, d);
    check("t4_overflow_cleared", d, 64'h0);
    check("t4_vec3", 64'(interrupt_vector), 64'h3);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    ticks(2);

    // Masking; simultaneous write and read returns the old ENABLE.
    bus_address = BASE + 64'h08; bus_write_data = 64'h0;
    bus_write_enable = 1'b1; bus_read_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0; bus_read_enable = 1'b0;
    check("t5_read_before_write", bus_read_data, 64'hFF);
    pulse(0);
    ticks(3);
    check("t5_masked_vec0", 64'(interrupt_vector), 64'h0);
    bus_rd(BASE + 64'h00, d);
    check("t5_pending01", d, 64'h01);
    bus_wr(BASE + 64'h08, 64'h01);
    wait_vec("t5_vec1", 1, 3);
    bus_wr(BASE + 64'h08, 64'h00);
    wait_vec("t5_withdraw", 0, 2);
    bus_rd(BASE + 64'h00, d);
    check("t5_pending_kept", d, 64'h01);
    bus_wr(BASE + 64'h08, 64'hFF);
    wait_vec("t5_vec1_again", 1, 3);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    ticks(2);

    // Asynchronous reset mid-handshake.
    pulse(4);
    wait_vec("t6_vec5", 5, 5);
    #3;
    KEY0 = 1'b0;
    #1;
    check("t6_async_reset_vec", 64'(interrupt_vector), 64'h0);
    model_reset();
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    bus_rd(BASE + 64'h08, d);
    check("t6_enable_reset", d, 64'hFF);
    bus_rd(BASE + 64'h00, d);
    check("t6_pending_reset", d, 64'h0);
    bus_rd(BASE + 64'h18, d);
    check("t6_current_reset", d, 64'h0);

    // Level source re-pends while held high.
    irq_src[7] = 1'b1;
    wait_vec("t6_level_vec8", 8, 6);
    interrupt_ack = 1'b1;
    tick();
    check("t6_level_ack", 64'(interrupt_vector), 64'h0);
    interrupt_ack = 1'b0;
    wait_vec("t6_level_repend", 8, 3);
    irq_src[7] = 1'b0;
    ticks(3);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    ticks(3);
    check("t6_level_done", 64'(interrupt_vector), 64'h0);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      int unsigned r;
      logic [7:0]  flip;
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      irq_src = irq_src ^ flip;
      interrupt_ack = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      bus_address = BASE + 64'($urandom_range(0, 3) * 8);
      if ($urandom_range(0, 7) == 0) begin
        bus_address = ($urandom_range(0, 1) == 1) ? BASE + 64'h20 : BASE - 64'h8;
      end
      bus_write_enable = (r == 0);
      bus_read_enable  = (r == 1) || (r == 2);
      bus_write_data   = {$urandom, $urandom};
      tick();
    end
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
    interrupt_ack    = 1'b0;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
